// File: rtl/elink_byte_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : elink_byte_aligner
//  Description : Receive-side bit aligner for N_LINKS elinks. Each link scans
//                a 16-bit window {previous byte, current byte} for SYNC_BYTE,
//                verifies it LOCK_COUNT times at the same bit offset, then
//                locks. Once every link is locked, aligned bytes are forwarded
//                on an AXI-Stream output register.
//  Ports       : clk160, clk160_aresetn       - clock, async active-low reset
//                S_AXIS_tdata/tvalid/tready   - raw bytes in, link i at [8i+:8]
//                M_AXIS_tdata/tvalid/tready   - aligned bytes out
//                relock                       - per-link restart-search pulse
//                locked                       - per-link lock status
//                offset                       - per-link bit offset, [3i+:3]
//  Revision    : 1.0 - initial release
// ============================================================================
module elink_byte_aligner #(
    parameter int          N_LINKS    = 1,
    parameter logic [7:0]  SYNC_BYTE  = 8'h9C,
    parameter int          LOCK_COUNT = 4
) (
    input  logic                   clk160,
    input  logic                   clk160_aresetn,
    input  logic [N_LINKS*8-1:0]   S_AXIS_tdata,
    input  logic                   S_AXIS_tvalid,
    output logic                   S_AXIS_tready,
    output logic [N_LINKS*8-1:0]   M_AXIS_tdata,
    output logic                   M_AXIS_tvalid,
    input  logic                   M_AXIS_tready,
    input  logic [N_LINKS-1:0]     relock,
    output logic [N_LINKS-1:0]     locked,
    output logic [N_LINKS*3-1:0]   offset
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    logic                  accept_w;
    logic                  all_locked_w;
    logic [N_LINKS*8-1:0]  aligned_w;
    logic                  m_valid_q, m_valid_d;
    logic [N_LINKS*8-1:0]  m_data_q, m_data_d;

    // Input is blocked only while a beat is stalled in the output register.
    assign S_AXIS_tready = !m_valid_q || M_AXIS_tready;
    assign accept_w      = S_AXIS_tvalid && S_AXIS_tready;
    assign all_locked_w  = &locked;

    generate
        for (genvar i = 0; i < N_LINKS; i++) begin : g_link
            state_t            state_q, state_d;
            logic [CNT_W-1:0]  cnt_q, cnt_d;
            logic [CNT_W-1:0]  cnt_inc_w;
            logic [2:0]        off_q, off_d;
            logic [7:0]        prev_q;
            logic [15:0]       win_w;
            logic              hit_w;
            logic [2:0]        hit_k_w;

            assign win_w     = {prev_q, S_AXIS_tdata[8*i +: 8]};
            assign cnt_inc_w = cnt_q + CNT_W'(1);

            // Scan from the top so the lowest matching offset wins.
            always_comb begin
                hit_w   = 1'b0;
                hit_k_w = 3'd0;
                for (int k = 7; k >= 0; k--) begin
                    if (win_w[k +: 8] == SYNC_BYTE) begin
                        hit_w   = 1'b1;
                        hit_k_w = 3'(k);
                    end
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                off_d   = off_q;
                if (relock[i]) begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end else if (accept_w) begin
                    case (state_q)
                        ST_SEARCH: begin
                            if (hit_w) begin
                                off_d   = hit_k_w;
                                cnt_d   = CNT_W'(1);
                                state_d = ST_VERIFY;
                            end
                        end
                        ST_VERIFY: begin
                            if (win_w[off_q +: 8] == SYNC_BYTE) begin
                                cnt_d = cnt_inc_w;
                                if (cnt_inc_w == CNT_W'(LOCK_COUNT)) begin
                                    state_d = ST_LOCKED;
                                end
                            end else begin
                                // Offset is intentionally retained on a break.
                                state_d = ST_SEARCH;
                                cnt_d   = '0;
                            end
                        end
                        ST_LOCKED: ;
                        default: begin
                            state_d = ST_SEARCH;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk160 or negedge clk160_aresetn) begin
                if (!clk160_aresetn) begin
                    state_q <= ST_SEARCH;
                    cnt_q   <= '0;
                    off_q   <= 3'd0;
                    prev_q  <= 8'd0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    off_q   <= off_d;
                    // History follows every accepted byte, relock or not.
                    if (accept_w) begin
                        prev_q <= S_AXIS_tdata[8*i +: 8];
                    end
                end
            end

            assign locked[i]            = (state_q == ST_LOCKED);
            assign offset[3*i +: 3]     = off_q;
            assign aligned_w[8*i +: 8]  = win_w[off_q +: 8];
        end
    endgenerate

    // Output register: lock state is sampled before this edge's update, so the
    // byte that completes lock is dropped and a pending beat is never withdrawn.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (accept_w && all_locked_w) begin
            m_valid_d = 1'b1;
            m_data_d  = aligned_w;
        end else if (m_valid_q && M_AXIS_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk160 or negedge clk160_aresetn) begin
        if (!clk160_aresetn) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign M_AXIS_tvalid = m_valid_q;
    assign M_AXIS_tdata  = m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_elink_byte_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_elink_byte_aligner
//  Description : Self-checking bench; a one-link instance is driven from a
//                vector table, a two-link instance by a hand-written sequence,
//                followed by an asynchronous reset mid-stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elink_byte_aligner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // One-link instance
    logic [7:0]  s1_data;
    logic        s1_valid, s1_ready;
    logic [7:0]  m1_data;
    logic        m1_valid, m1_ready;
    logic [0:0]  rl1, lk1;
    logic [2:0]  off1;

    elink_byte_aligner #(.N_LINKS(1), .SYNC_BYTE(8'h9C), .LOCK_COUNT(4)) dut1 (
        .clk160(clk), .clk160_aresetn(rst_n),
        .S_AXIS_tdata(s1_data), .S_AXIS_tvalid(s1_valid), .S_AXIS_tready(s1_ready),
        .M_AXIS_tdata(m1_data), .M_AXIS_tvalid(m1_valid), .M_AXIS_tready(m1_ready),
        .relock(rl1), .locked(lk1), .offset(off1)
    );

    // Two-link instance
    logic [15:0] s2_data;
    logic        s2_valid, s2_ready;
    logic [15:0] m2_data;
    logic        m2_valid, m2_ready;
    logic [1:0]  rl2, lk2;
    logic [5:0]  off2;

    elink_byte_aligner #(.N_LINKS(2), .SYNC_BYTE(8'h9C), .LOCK_COUNT(4)) dut2 (
        .clk160(clk), .clk160_aresetn(rst_n),
        .S_AXIS_tdata(s2_data), .S_AXIS_tvalid(s2_valid), .S_AXIS_tready(s2_ready),
        .M_AXIS_tdata(m2_data), .M_AXIS_tvalid(m2_valid), .M_AXIS_tready(m2_ready),
        .relock(rl2), .locked(lk2), .offset(off2)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       mr;
        logic       rl;
        logic       e_lk;
        logic [2:0] e_off;
        logic       e_mv;
        logic [7:0] e_md;
        logic       e_sr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic mr,
                                input logic rl, input logic e_lk, input logic [2:0] e_off,
                                input logic e_mv, input logic [7:0] e_md, input logic e_sr);
        vec_t t;
        t.v = v; t.d = d; t.mr = mr; t.rl = rl;
        t.e_lk = e_lk; t.e_off = e_off; t.e_mv = e_mv; t.e_md = e_md; t.e_sr = e_sr;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step2(input logic [15:0] d, input logic [1:0] rl,
                         input logic [1:0] e_lk, input logic e_mv, input logic [15:0] e_md,
                         input string tag);
        s2_valid = 1'b1; s2_data = d; rl2 = rl; m2_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".locked"}, 32'(lk2), 32'(e_lk));
        check({tag, ".mvalid"}, 32'(m2_valid), 32'(e_mv));
        if (e_mv) check({tag, ".mdata"}, 32'(m2_data), 32'(e_md));
        @(negedge clk);
    endtask

    initial begin
        s1_valid = 1'b0; s1_data = 8'h00; m1_ready = 1'b1; rl1 = 1'b0;
        s2_valid = 1'b0; s2_data = 16'h0; m2_ready = 1'b1; rl2 = 2'b00;

        //          v  data   mr rl  lk off mv  mdata  sr
        // Sync 9C at offset 0, then first forwarded byte
        vq.push_back(mk(1, 8'h9C, 1, 0, 0, 3'd0, 0, 8'h00, 1));
        vq.push_back(mk(1, 8'h9C, 1, 0, 0, 3'd0, 0, 8'h00, 1));
        vq.push_back(mk(1, 8'h9C, 1, 0, 0, 3'd0, 0, 8'h00, 1));
        vq.push_back(mk(1, 8'h9C, 1, 0, 1, 3'd0, 0, 8'h00, 1));
        vq.push_back(mk(1, 8'h12, 1, 0, 1, 3'd0, 1, 8'h12, 1));
        // Backpressure: beat 0x12 held for 5 cycles, input blocked
        for (int n = 0; n < 5; n++)
            vq.push_back(mk(1, 8'h34, 0, 0, 1, 3'd0, 1, 8'h12, 0));
        vq.push_back(mk(1, 8'h34, 1, 0, 1, 3'd0, 1, 8'h34, 1));
        vq.push_back(mk(1, 8'h56, 1, 0, 1, 3'd0, 1, 8'h56, 1));
        vq.push_back(mk(0, 8'h00, 1, 0, 1, 3'd0, 0, 8'h56, 1));
        // Relock with a byte accepted the same cycle: still forwarded
        vq.push_back(mk(1, 8'h00, 1, 1, 0, 3'd0, 1, 8'h00, 1));
        // 0xE4 stream: window {00,E4} has no match, then offset 3
        vq.push_back(mk(1, 8'hE4, 1, 0, 0, 3'd0, 0, 8'h00, 1));
        vq.push_back(mk(1, 8'hE4, 1, 0, 0, 3'd3, 0, 8'h00, 1));
        vq.push_back(mk(1, 8'hE4, 1, 0, 0, 3'd3, 0, 8'h00, 1));
        vq.push_back(mk(1, 8'hE4, 1, 0, 0, 3'd3, 0, 8'h00, 1));
        vq.push_back(mk(1, 8'hE4, 1, 0, 1, 3'd3, 0, 8'h00, 1));
        // {E4,00}[10:3] = 0x80
        vq.push_back(mk(1, 8'h00, 1, 0, 1, 3'd3, 1, 8'h80, 1));
        // Relock, then VERIFY broken by 0x00
        vq.push_back(mk(0, 8'h00, 1, 1, 0, 3'd3, 0, 8'h80, 1));
        vq.push_back(mk(1, 8'h9C, 1, 0, 0, 3'd0, 0, 8'h80, 1));
        vq.push_back(mk(1, 8'h9C, 1, 0, 0, 3'd0, 0, 8'h80, 1));
        vq.push_back(mk(1, 8'h00, 1, 0, 0, 3'd0, 0, 8'h80, 1));
        vq.push_back(mk(1, 8'h9C, 1, 0, 0, 3'd0, 0, 8'h80, 1));
        vq.push_back(mk(1, 8'h9C, 1, 0, 0, 3'd0, 0, 8'h80, 1));
        vq.push_back(mk(1, 8'h9C, 1, 0, 0, 3'd0, 0, 8'h80, 1));
        vq.push_back(mk(1, 8'h9C, 1, 0, 1, 3'd0, 0, 8'h80, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.locked", 32'(lk1), 32'd0);
        check("rst.offset", 32'(off1), 32'd0);
        check("rst.mvalid", 32'(m1_valid), 32'd0);
        check("rst.mdata",  32'(m1_data), 32'd0);
        check("rst.sready", 32'(s1_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            s1_valid = vq[i].v; s1_data = vq[i].d; m1_ready = vq[i].mr; rl1 = vq[i].rl;
            @(posedge clk); #1;
            check($sformatf("v%0d.locked", i), 32'(lk1), 32'(vq[i].e_lk));
            check($sformatf("v%0d.offset", i), 32'(off1), 32'(vq[i].e_off));
            check($sformatf("v%0d.mvalid", i), 32'(m1_valid), 32'(vq[i].e_mv));
            check($sformatf("v%0d.mdata", i), 32'(m1_data), 32'(vq[i].e_md));
            check($sformatf("v%0d.sready", i), 32'(s1_ready), 32'(vq[i].e_sr));
            @(negedge clk);
        end
        s1_valid = 1'b0; rl1 = 1'b0;

        // Two links: link1 first sees sync three bytes after link0
        step2(16'h009C, 2'b00, 2'b00, 1'b0, 16'h0, "l2a1");
        step2(16'h009C, 2'b00, 2'b00, 1'b0, 16'h0, "l2a2");
        step2(16'h009C, 2'b00, 2'b00, 1'b0, 16'h0, "l2a3");
        step2(16'h9C9C, 2'b00, 2'b01, 1'b0, 16'h0, "l2a4");
        step2(16'h9C9C, 2'b00, 2'b01, 1'b0, 16'h0, "l2a5");
        step2(16'h9C9C, 2'b00, 2'b01, 1'b0, 16'h0, "l2a6");
        step2(16'h9C9C, 2'b00, 2'b11, 1'b0, 16'h0, "l2a7");
        step2(16'hABCD, 2'b00, 2'b11, 1'b1, 16'hABCD, "l2a8");
        step2(16'h1122, 2'b01, 2'b10, 1'b1, 16'h1122, "l2a9");
        step2(16'h3344, 2'b00, 2'b10, 1'b0, 16'h0, "l2a10");
        check("l2.offset", 32'(off2), 32'd0);
        s2_valid = 1'b0;

        // Async reset while a beat is held in the output register
        s1_valid = 1'b1; s1_data = 8'h77; m1_ready = 1'b0;
        @(posedge clk); #1;
        check("ar.pre_mvalid", 32'(m1_valid), 32'd1);
        check("ar.pre_mdata",  32'(m1_data), 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.mvalid", 32'(m1_valid), 32'd0);
        check("ar.locked", 32'(lk1), 32'd0);
        check("ar.offset", 32'(off1), 32'd0);
        check("ar.mdata",  32'(m1_data), 32'd0);
        s1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
